// File: rtl/rk_sdram_arbiter.sv
// rk_sdram_arbiter
// Shares the single SDRAM controller port between three users:
//   - the CPU (reads and writes),
//   - the video DMA (reads only),
//   - an internal periodic auto-refresh generator.
// Priority is fixed: REF > VID > CPU. A starvation guard lets a CPU that has
// waited CPU_MAXWAIT cycles outrank the video DMA; refresh still goes first.
// Only one transaction is outstanding at a time, and grants are never pipelined.
//
// Ports
//   clk, reset_n                 50 MHz clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata        CPU request (level, held until cpu_done)
//   cpu_done, cpu_rdata          CPU completion pulse and held read data
//   vid_req/addr                 DMA read request (level, held until vid_done)
//   vid_done, vid_rdata          DMA completion pulse and held read data
//   mem_req/ref/we/addr/wdata    request to the SDRAM controller, held until mem_ack
//   mem_ack, mem_rdata           one-cycle completion and read data from the controller
//   tmo_flag                     sticky flag: some transaction timed out
module rk_sdram_arbiter #(
    parameter int ADDR_W      = 18,
    parameter int REF_PERIOD  = 390,
    parameter int CPU_MAXWAIT = 16,
    parameter int ACK_TMO     = 63
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_done,
    output logic [7:0]        cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_done,
    output logic [7:0]        vid_rdata,
    output logic              mem_req,
    output logic              mem_ref,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              tmo_flag
);
    localparam int REF_W  = $clog2(REF_PERIOD);
    localparam int WAIT_W = $clog2(CPU_MAXWAIT + 1);
    localparam int TMO_W  = $clog2(ACK_TMO + 1);
    localparam logic [REF_W-1:0]  REF_LAST = REF_W'(REF_PERIOD - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAXWAIT);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(ACK_TMO - 1);

    typedef enum logic [2:0] {IDLE, S_REF, S_VID, S_CPU, S_DONE} state_t;

    state_t             state;
    state_t             next_state;
    logic [REF_W-1:0]   ref_cnt;
    logic               ref_pend;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               grant;
    logic               ack_end;
    logic               tmo_end;
    logic               ref_wrap;

    assign ref_wrap = (ref_cnt == REF_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Arbitration and transaction termination. An ack in the same cycle as
    // the timeout wins, so a late-but-valid completion is never discarded.
    always_comb begin
        next_state = state;
        grant      = 1'b0;
        ack_end    = 1'b0;
        tmo_end    = 1'b0;
        case (state)
            IDLE: begin
                if (ref_pend) begin
                    next_state = S_REF;
                end else if (cpu_req && (wait_cnt == WAIT_MAX)) begin
                    next_state = S_CPU;
                end else if (vid_req) begin
                    next_state = S_VID;
                end else if (cpu_req) begin
                    next_state = S_CPU;
                end
                grant = (next_state != IDLE);
            end
            S_REF, S_VID, S_CPU: begin
                if (mem_ack) begin
                    next_state = S_DONE;
                    ack_end    = 1'b1;
                end else if (tmo_cnt == TMO_LAST) begin
                    next_state = S_DONE;
                    tmo_end    = 1'b1;
                end
            end
            S_DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Refresh timer. A wrap landing on the same edge as entry to S_REF keeps
    // ref_pend set, because that wrap represents a further refresh owed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ref_cnt  <= '0;
            ref_pend <= 1'b0;
        end else if (ref_wrap) begin
            ref_cnt  <= '0;
            ref_pend <= 1'b1;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
            if (grant && (next_state == S_REF)) begin
                ref_pend <= 1'b0;
            end
        end
    end

    // CPU starvation counter, saturating at CPU_MAXWAIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (!cpu_req || (grant && (next_state == S_CPU))) begin
            wait_cnt <= '0;
        end else if ((state != S_CPU) && (wait_cnt != WAIT_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Controller-side request registers, completion pulses and read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_req   <= 1'b0;
            mem_ref   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            tmo_cnt   <= '0;
            cpu_done  <= 1'b0;
            vid_done  <= 1'b0;
            cpu_rdata <= '0;
            vid_rdata <= '0;
            tmo_flag  <= 1'b0;
        end else begin
            cpu_done <= 1'b0;
            vid_done <= 1'b0;
            if (grant) begin
                mem_req <= 1'b1;
                tmo_cnt <= '0;
                if (next_state == S_REF) begin
                    mem_ref   <= 1'b1;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                end else if (next_state == S_VID) begin
                    mem_ref   <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= vid_addr;
                    mem_wdata <= '0;
                end else begin
                    mem_ref   <= 1'b0;
                    mem_we    <= cpu_we;
                    mem_addr  <= cpu_addr;
                    mem_wdata <= cpu_wdata;
                end
            end else if (ack_end || tmo_end) begin
                mem_req <= 1'b0;
                if (tmo_end) begin
                    tmo_flag <= 1'b1;
                end
                if (state == S_CPU) begin
                    cpu_done <= 1'b1;
                    if (!mem_we) begin
                        cpu_rdata <= tmo_end ? 8'hFF : mem_rdata;
                    end
                end
                if (state == S_VID) begin
                    vid_done  <= 1'b1;
                    vid_rdata <= tmo_end ? 8'hFF : mem_rdata;
                end
            end else if (mem_req) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rk_sdram_arbiter.sv
// tb_rk_sdram_arbiter
// Directed bench for rk_sdram_arbiter. The stimulus process drives requests
// and pushes the expected grant/done events into a scoreboard queue; a
// monitor on the falling edge pops and compares every grant (mem_req rise)
// and every done pulse. A simple controller model acks after ack_delay
// cycles with mem_rdata = mem_addr[7:0] ^ 8'h6E (or never, when ack_en=0).
`timescale 1ns/1ps
module tb_rk_sdram_arbiter;
    localparam int ADDR_W = 18;
    localparam logic [1:0] K_GRANT = 2'd0;
    localparam logic [1:0] K_CPU   = 2'd1;
    localparam logic [1:0] K_VID   = 2'd2;

    typedef struct packed {
        logic [1:0]        kind;
        logic              ref_f;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
        logic              chk_data;
    } ev_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_done;
    logic [7:0]        cpu_rdata;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_done;
    logic [7:0]        vid_rdata;
    logic              mem_req;
    logic              mem_ref;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ack;
    logic [7:0]        mem_rdata;
    logic              tmo_flag;

    int  checks = 0;
    int  failures = 0;
    int  ref_seen = 0;
    int  ack_delay = 1;
    bit  ack_en = 1'b1;
    ev_t sb[$];
    ev_t got;
    ev_t exp_ev;
    logic prev_req;

    rk_sdram_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_done  (cpu_done),
        .cpu_rdata (cpu_rdata),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_done  (vid_done),
        .vid_rdata (vid_rdata),
        .mem_req   (mem_req),
        .mem_ref   (mem_ref),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .tmo_flag  (tmo_flag)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic push_grant(input logic ref_f, input logic we, input logic [ADDR_W-1:0] addr,
                              input logic [7:0] data, input logic chk);
        ev_t e;
        e.kind = K_GRANT; e.ref_f = ref_f; e.we = we; e.addr = addr; e.data = data; e.chk_data = chk;
        sb.push_back(e);
    endtask

    task automatic push_done(input logic [1:0] kind, input logic [7:0] data, input logic chk);
        ev_t e;
        e.kind = kind; e.ref_f = 1'b0; e.we = 1'b0; e.addr = '0; e.data = data; e.chk_data = chk;
        sb.push_back(e);
    endtask

    // Waits for a condition checked #1 after each rising edge; n = cycles, -1 on timeout.
    // sel: 0 cpu_done, 1 vid_done, 2 mem_req high, 3 mem_req low.
    task automatic wait_sig(input int sel, input int max_cyc, output int n);
        bit seen;
        logic v;
        seen = 1'b0;
        n = -1;
        for (int i = 1; i <= max_cyc && !seen; i++) begin
            @(posedge clk);
            #1;
            case (sel)
                0: v = cpu_done;
                1: v = vid_done;
                2: v = mem_req;
                default: v = !mem_req;
            endcase
            if (v) begin
                seen = 1'b1;
                n = i;
            end
        end
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        vid_req   = 1'b0;
        vid_addr  = '0;
        ack_en    = 1'b1;
        ack_delay = 1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic idle_and_drain(input string name);
        repeat (4) @(posedge clk);
        #1;
        check_output({name, "_no_regrant"}, {31'd0, mem_req}, 32'd0);
        check_output({name, "_sb_empty"}, sb.size(), 32'd0);
    endtask

    // Controller model.
    initial begin : responder
        int  cnt;
        bit  acked;
        cnt = 0;
        acked = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (!mem_req) begin
                cnt = 0;
                acked = 1'b0;
            end else if (!acked) begin
                cnt++;
                if (ack_en && cnt == ack_delay) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_addr[7:0] ^ 8'h6E;
                    acked = 1'b1;
                end
            end
        end
    end

    // Scoreboard monitor.
    initial begin : monitor
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                bit fire;
                fire = 1'b0;
                got = '0;
                if (k == 0 && mem_req && !prev_req) begin
                    fire = 1'b1;
                    got.kind = K_GRANT; got.ref_f = mem_ref; got.we = mem_we;
                    got.addr = mem_addr; got.data = mem_wdata;
                    if (mem_ref) ref_seen++;
                end else if (k == 1 && cpu_done) begin
                    fire = 1'b1;
                    got.kind = K_CPU; got.data = cpu_rdata;
                end else if (k == 2 && vid_done) begin
                    fire = 1'b1;
                    got.kind = K_VID; got.data = vid_rdata;
                end
                if (fire) begin
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("[TB] FAIL sb_unexpected: got kind=%0d ref=%0b addr=%h data=%h, expected no event",
                                 got.kind, got.ref_f, got.addr, got.data);
                    end else begin
                        bit ok;
                        exp_ev = sb.pop_front();
                        ok = (got.kind == exp_ev.kind);
                        if (ok && exp_ev.kind == K_GRANT) begin
                            ok = (got.ref_f == exp_ev.ref_f) && (got.we == exp_ev.we);
                            if (!exp_ev.ref_f) ok = ok && (got.addr == exp_ev.addr);
                        end
                        if (ok && exp_ev.chk_data) ok = (got.data == exp_ev.data);
                        if (!ok) begin
                            failures++;
                            $display("[TB] FAIL sb_event: got kind=%0d ref=%0b we=%0b addr=%h data=%h, expected kind=%0d ref=%0b we=%0b addr=%h data=%h",
                                     got.kind, got.ref_f, got.we, got.addr, got.data,
                                     exp_ev.kind, exp_ev.ref_f, exp_ev.we, exp_ev.addr, exp_ev.data);
                        end
                    end
                end
            end
            prev_req = mem_req;
        end
    end

    initial begin : watchdog
        #(5000 * 10);
        $display("[TB] FAIL watchdog: simulation exceeded 5000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int n;
        int found;

        // Reset values while reset_n is held low.
        reset_n = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        vid_req = 1'b0; vid_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_output("rst_mem_ctrl", {4'd0, mem_ref, mem_we, mem_addr, mem_wdata}, 32'd0);
        check_output("rst_done", {30'd0, cpu_done, vid_done}, 32'd0);
        check_output("rst_rdata", {16'd0, cpu_rdata, vid_rdata}, 32'd0);
        check_output("rst_tmo", {31'd0, tmo_flag}, 32'd0);

        // 1: CPU read, ack three cycles after mem_req.
        do_reset();
        ack_delay = 3;
        cpu_we = 1'b0; cpu_addr = 18'h01234; cpu_req = 1'b1;
        push_grant(1'b0, 1'b0, 18'h01234, 8'h00, 1'b0);
        push_done(K_CPU, 8'h5A, 1'b1);
        @(posedge clk);
        #1;
        check_output("t1_req_latency", {31'd0, mem_req}, 32'd1);
        check_output("t1_mem_addr", {14'd0, mem_addr}, 32'h01234);
        wait_sig(0, 10, n);
        check_output("t1_done_cycles", n, 32'd3);
        check_output("t1_cpu_rdata", {24'd0, cpu_rdata}, 32'h5A);
        cpu_req = 1'b0;
        idle_and_drain("t1");

        // 2: CPU write and VID request raised together.
        do_reset();
        ack_delay = 2;
        cpu_we = 1'b1; cpu_addr = 18'h2ABCD; cpu_wdata = 8'hC3; cpu_req = 1'b1;
        vid_addr = 18'h00110; vid_req = 1'b1;
        push_grant(1'b0, 1'b0, 18'h00110, 8'h00, 1'b0);
        push_done(K_VID, 8'h7E, 1'b1);
        push_grant(1'b0, 1'b1, 18'h2ABCD, 8'hC3, 1'b1);
        push_done(K_CPU, 8'h00, 1'b0);
        wait_sig(1, 10, n);
        check_output("t2_vid_done_cycles", n, 32'd3);
        vid_req = 1'b0;
        wait_sig(2, 10, n);
        check_output("t2_cpu_grant_gap", n, 32'd2);
        check_output("t2_mem_we", {31'd0, mem_we}, 32'd1);
        check_output("t2_mem_wdata", {24'd0, mem_wdata}, 32'hC3);
        wait_sig(0, 10, n);
        check_output("t2_cpu_done_cycles", n, 32'd2);
        cpu_req = 1'b0; cpu_we = 1'b0;
        idle_and_drain("t2");

        // 3: VID held continuously, CPU read held; starvation guard.
        do_reset();
        ack_delay = 1;
        vid_addr = 18'h00222; vid_req = 1'b1;
        cpu_we = 1'b0; cpu_addr = 18'h00345; cpu_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_grant(1'b0, 1'b0, 18'h00222, 8'h00, 1'b0);
            push_done(K_VID, 8'h4C, 1'b1);
        end
        push_grant(1'b0, 1'b0, 18'h00345, 8'h00, 1'b0);
        push_done(K_CPU, 8'h2B, 1'b1);
        for (int i = 0; i < 2; i++) begin
            push_grant(1'b0, 1'b0, 18'h00222, 8'h00, 1'b0);
            push_done(K_VID, 8'h4C, 1'b1);
        end
        found = -1;
        for (int i = 1; i <= 60 && found < 0; i++) begin
            @(posedge clk);
            #1;
            if (mem_req && !mem_ref && mem_addr == 18'h00345) found = i;
        end
        check_output("t3_cpu_grant_cycle", found, 32'd19);
        wait_sig(0, 5, n);
        check_output("t3_cpu_done_cycles", n, 32'd1);
        cpu_req = 1'b0;
        wait_sig(1, 10, n);
        check_output("t3_vid_resume", n, 32'd3);
        wait_sig(1, 10, n);
        check_output("t3_vid_next", n, 32'd3);
        vid_req = 1'b0;
        idle_and_drain("t3");

        // 4: refresh insertion under continuous VID traffic, two periods.
        do_reset();
        ack_delay = 1;
        ref_seen = 0;
        vid_addr = 18'h00333; vid_req = 1'b1;
        for (int i = 0; i < 130; i++) begin
            push_grant(1'b0, 1'b0, 18'h00333, 8'h00, 1'b0);
            push_done(K_VID, 8'h5D, 1'b1);
        end
        push_grant(1'b1, 1'b0, 18'h00000, 8'h00, 1'b0);
        for (int i = 0; i < 129; i++) begin
            push_grant(1'b0, 1'b0, 18'h00333, 8'h00, 1'b0);
            push_done(K_VID, 8'h5D, 1'b1);
        end
        push_grant(1'b1, 1'b0, 18'h00000, 8'h00, 1'b0);
        repeat (782) @(posedge clk);
        #1;
        vid_req = 1'b0;
        idle_and_drain("t4");
        check_output("t4_ref_count", ref_seen, 32'd2);

        // 5: CPU read with the ack withheld, then a normal read.
        do_reset();
        ack_en = 1'b0;
        cpu_we = 1'b0; cpu_addr = 18'h00456; cpu_req = 1'b1;
        push_grant(1'b0, 1'b0, 18'h00456, 8'h00, 1'b0);
        push_done(K_CPU, 8'hFF, 1'b1);
        push_grant(1'b0, 1'b0, 18'h00481, 8'h00, 1'b0);
        push_done(K_CPU, 8'hEF, 1'b1);
        wait_sig(2, 5, n);
        check_output("t5_req_latency", n, 32'd1);
        wait_sig(3, 100, n);
        check_output("t5_tmo_cycles", n, 32'd63);
        check_output("t5_tmo_done", {31'd0, cpu_done}, 32'd1);
        check_output("t5_tmo_flag", {31'd0, tmo_flag}, 32'd1);
        check_output("t5_tmo_rdata", {24'd0, cpu_rdata}, 32'hFF);
        cpu_req = 1'b0;
        ack_en = 1'b1;
        ack_delay = 1;
        repeat (2) @(posedge clk);
        #1;
        cpu_addr = 18'h00481; cpu_req = 1'b1;
        wait_sig(0, 10, n);
        check_output("t5_read_after_tmo", n, 32'd2);
        check_output("t5_rdata_after_tmo", {24'd0, cpu_rdata}, 32'hEF);
        check_output("t5_tmo_sticky", {31'd0, tmo_flag}, 32'd1);
        cpu_req = 1'b0;
        idle_and_drain("t5");

        // 6: reset asserted while a VID read is in flight.
        do_reset();
        ack_en = 1'b0;
        vid_addr = 18'h00544; vid_req = 1'b1;
        push_grant(1'b0, 1'b0, 18'h00544, 8'h00, 1'b0);
        wait_sig(2, 5, n);
        check_output("t6_grant_latency", n, 32'd1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_output("t6_async_req_drop", {31'd0, mem_req}, 32'd0);
        ack_delay = 2;
        ack_en = 1'b1;
        push_grant(1'b0, 1'b0, 18'h00544, 8'h00, 1'b0);
        push_done(K_VID, 8'h2A, 1'b1);
        @(posedge clk);
        #1;
        check_output("t6_no_done_in_reset", {31'd0, vid_done}, 32'd0);
        reset_n = 1'b1;
        wait_sig(2, 5, n);
        check_output("t6_regrant_latency", n, 32'd1);
        wait_sig(1, 10, n);
        check_output("t6_done_cycles", n, 32'd2);
        check_output("t6_vid_rdata", {24'd0, vid_rdata}, 32'h2A);
        vid_req = 1'b0;
        idle_and_drain("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
